// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: ping-pong sample buffer feeding fftmain.
// ADC samples fill one of two FFT_SIZE-deep banks while the other bank is streamed
// out as {real, imag=0} words, one ce_out strobe every OUT_GAP+1 clocks.
module fft_frame_feeder #(
  parameter int FFT_SIZE = 2048,
  parameter int SAMPLE_W = 16,
  parameter int OUT_GAP  = 0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  sample_valid_in,
  input  logic [SAMPLE_W-1:0]   sample_in,
  input  logic                  frame_req_in,
  output logic                  ce_out,
  output logic [2*SAMPLE_W-1:0] sample_out,
  output logic                  frame_start_out,
  output logic                  frame_done_out,
  output logic                  overflow_out
);

  localparam int AW = $clog2(FFT_SIZE);
  localparam int GW = (OUT_GAP > 0) ? $clog2(OUT_GAP + 1) : 1;
  localparam logic [AW-1:0] LAST    = AW'(FFT_SIZE - 1);
  localparam logic [GW-1:0] GAP_RLD = GW'(OUT_GAP);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_READING} bank_e;
  typedef enum logic [1:0] {R_IDLE, R_STREAM, R_DONE} rd_e;

  // Bank bookkeeping
  bank_e         bank_q [2];
  logic          older_q;      // bank that reached FULL first when both are FULL

  // Writer state
  logic          filling_q;    // writer owns a FILLING bank
  logic          wr_bank_q;
  logic [AW-1:0] wr_idx_q;

  // Reader state
  rd_e           rd_state_q;
  logic          rd_bank_q;
  logic [AW-1:0] rd_idx_q;
  logic [GW-1:0] gap_q;
  logic          issued_all_q;
  logic          rd_vld_q, rd_first_q, rd_last_q;
  logic [SAMPLE_W-1:0] ram_q;

  logic [SAMPLE_W-1:0] mem [2*FFT_SIZE];

  // Combinational handshake between writer and reader
  logic [1:0]    full_v, free_v, take_v, eff_empty;
  logic          start, take_bank;
  logic          claim, claim_bank, cur_bank, wr_en, complete, drop;
  logic [AW-1:0] cur_idx;

  // Bank arbitration: which bank the reader takes/frees and where the writer stores
  always_comb begin
    full_v    = '0;
    free_v    = '0;
    take_v    = '0;
    eff_empty = '0;
    for (int b = 0; b < 2; b++) full_v[b] = (bank_q[b] == B_FULL);
    if (rd_state_q == R_DONE) free_v[rd_bank_q] = 1'b1;
    take_bank = (full_v == 2'b11) ? older_q : full_v[1];
    start     = (rd_state_q == R_IDLE) && frame_req_in && (|full_v);
    if (start) take_v[take_bank] = 1'b1;
    // A bank released by the reader this cycle is immediately available to the writer.
    for (int b = 0; b < 2; b++) eff_empty[b] = (bank_q[b] == B_EMPTY) || free_v[b];
    claim      = !filling_q && (|eff_empty);
    claim_bank = !eff_empty[0];
    cur_bank   = filling_q ? wr_bank_q : claim_bank;
    cur_idx    = filling_q ? wr_idx_q : '0;
    wr_en      = sample_valid_in && (filling_q || claim);
    complete   = wr_en && (cur_idx == LAST);
    drop       = sample_valid_in && !wr_en;
  end

  // Sample RAM: write on accepted samples, synchronous read of the streaming bank
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[{cur_bank, cur_idx}] <= sample_in;
    ram_q <= mem[{rd_bank_q, rd_idx_q}];
  end

  // Writer, bank states and overflow flag
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bank_q[0]    <= B_EMPTY;
      bank_q[1]    <= B_EMPTY;
      older_q      <= 1'b0;
      filling_q    <= 1'b0;
      wr_bank_q    <= 1'b0;
      wr_idx_q     <= '0;
      overflow_out <= 1'b0;
    end else begin
      if (drop) overflow_out <= 1'b1;
      if (claim) begin
        filling_q <= 1'b1;
        wr_bank_q <= claim_bank;
        wr_idx_q  <= '0;
      end
      if (wr_en) begin
        wr_idx_q <= cur_idx + 1'b1;
        if (complete) filling_q <= 1'b0;
      end
      // Order tracking: the new FULL bank is oldest unless the other stays FULL.
      if (complete && (!full_v[!cur_bank] || take_v[!cur_bank])) older_q <= cur_bank;
      for (int b = 0; b < 2; b++) begin
        if (claim && (claim_bank == 1'(b)))        bank_q[b] <= B_FILLING;
        else if (complete && (cur_bank == 1'(b)))  bank_q[b] <= B_FULL;
        else if (take_v[b])                        bank_q[b] <= B_READING;
        else if (free_v[b])                        bank_q[b] <= B_EMPTY;
      end
    end
  end

  // Read FSM plus two-stage output pipeline (RAM read, then output register)
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_state_q      <= R_IDLE;
      rd_bank_q       <= 1'b0;
      rd_idx_q        <= '0;
      gap_q           <= '0;
      issued_all_q    <= 1'b0;
      rd_vld_q        <= 1'b0;
      rd_first_q      <= 1'b0;
      rd_last_q       <= 1'b0;
      ce_out          <= 1'b0;
      sample_out      <= '0;
      frame_start_out <= 1'b0;
      frame_done_out  <= 1'b0;
    end else begin
      rd_vld_q        <= 1'b0;
      frame_done_out  <= 1'b0;
      ce_out          <= rd_vld_q;
      frame_start_out <= rd_vld_q && rd_first_q;
      if (rd_vld_q) sample_out <= {ram_q, {SAMPLE_W{1'b0}}};
      case (rd_state_q)
        R_IDLE: begin
          if (start) begin
            rd_state_q   <= R_STREAM;
            rd_bank_q    <= take_bank;
            rd_idx_q     <= '0;
            gap_q        <= '0;
            issued_all_q <= 1'b0;
          end
        end
        R_STREAM: begin
          if (!issued_all_q) begin
            if (gap_q == '0) begin
              rd_vld_q   <= 1'b1;
              rd_first_q <= (rd_idx_q == '0);
              rd_last_q  <= (rd_idx_q == LAST);
              rd_idx_q   <= rd_idx_q + 1'b1;
              gap_q      <= GAP_RLD;
              if (rd_idx_q == LAST) issued_all_q <= 1'b1;
            end else begin
              gap_q <= gap_q - GW'(1);
            end
          end
          // Last word is leaving the RAM stage: its ce_out shows next cycle.
          if (rd_vld_q && rd_last_q) rd_state_q <= R_DONE;
        end
        R_DONE: begin
          frame_done_out <= 1'b1;
          rd_state_q     <= R_IDLE;
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Bench for fft_frame_feeder: FFT_SIZE=8, one instance with OUT_GAP=0, one with OUT_GAP=3.
module tb_fft_frame_feeder;
  localparam int N = 8;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          v0 = 1'b0, req0 = 1'b0, v1 = 1'b0, req1 = 1'b0;
  logic [W-1:0]  s0 = '0, s1 = '0;
  logic          ce0, fs0, fd0, ov0, ce1, fs1, fd1, ov1;
  logic [2*W-1:0] so0, so1;

  fft_frame_feeder #(.FFT_SIZE(N), .SAMPLE_W(W), .OUT_GAP(0)) dut (
    .clk_in(clk), .rst_in(rst), .sample_valid_in(v0), .sample_in(s0),
    .frame_req_in(req0), .ce_out(ce0), .sample_out(so0),
    .frame_start_out(fs0), .frame_done_out(fd0), .overflow_out(ov0));

  fft_frame_feeder #(.FFT_SIZE(N), .SAMPLE_W(W), .OUT_GAP(3)) dut_g (
    .clk_in(clk), .rst_in(rst), .sample_valid_in(v1), .sample_in(s1),
    .frame_req_in(req1), .ce_out(ce1), .sample_out(so1),
    .frame_start_out(fs1), .frame_done_out(fd1), .overflow_out(ov1));

  // Captured output streams
  int          cyc = 0;
  logic [31:0] g0_q[$], g1_q[$];
  int          g0_cyc[$], g1_cyc[$], d0_cyc[$];
  bit          g0_fs[$];
  logic [31:0] exp0[$], exp1[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (ce0) begin g0_q.push_back(so0); g0_cyc.push_back(cyc); g0_fs.push_back(fs0); end
    if (fd0) d0_cyc.push_back(cyc);
    if (ce1) begin g1_q.push_back(so1); g1_cyc.push_back(cyc); end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [W-1:0] s);
    return {s, 16'h0000};
  endfunction

  task automatic clear_caps();
    g0_q.delete(); g0_cyc.delete(); g0_fs.delete(); d0_cyc.delete();
    g1_q.delete(); g1_cyc.delete(); exp0.delete(); exp1.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_caps();
  endtask

  task automatic put0(input logic [W-1:0] s);
    v0 = 1'b1; s0 = s; exp0.push_back(word(s));
    @(posedge clk); #1;
    v0 = 1'b0;
  endtask

  task automatic put1(input logic [W-1:0] s);
    v1 = 1'b1; s1 = s; exp1.push_back(word(s));
    @(posedge clk); #1;
    v1 = 1'b0;
  endtask

  // Bounded wait for n captured words on instance 0, then a few clocks for frame_done.
  task automatic wait0(input string tag, input int n, input int budget);
    int k = 0;
    while (g0_q.size() < n && k < budget) begin @(posedge clk); k++; end
    repeat (3) @(posedge clk);
    #1 chk(tag, 32'(g0_q.size()), 32'(n));
  endtask

  // Compare instance-0 stream with the model: data, frame_start, frame_done timing.
  task automatic cmp0(input string tag);
    int nf = exp0.size() / N;
    for (int i = 0; i < exp0.size() && i < g0_q.size(); i++) begin
      chk({tag, "_data"}, g0_q[i], exp0[i]);
      chk({tag, "_fs"}, 32'(g0_fs[i]), 32'((i % N) == 0));
    end
    chk({tag, "_ndone"}, 32'(d0_cyc.size()), 32'(nf));
    for (int f = 0; f < nf && f < d0_cyc.size() && (f*N + N - 1) < g0_cyc.size(); f++)
      chk({tag, "_done_t"}, 32'(d0_cyc[f]), 32'(g0_cyc[f*N + N - 1] + 1));
  endtask

  initial begin
    int k;
    // Reset state
    #1;
    rst = 1'b1;
    #2;
    chk("rst_ce", 32'(ce0), 0);
    chk("rst_out", so0, 0);
    chk("rst_fs", 32'(fs0), 0);
    chk("rst_fd", 32'(fd0), 0);
    chk("rst_ovf", 32'(ov0), 0);

    // 1: one frame 1..8 with request already raised; words back to back
    do_reset();
    req0 = 1'b1;
    for (int i = 1; i <= N; i++) put0(W'(i));
    wait0("t1_cnt", N, 60);
    cmp0("t1");
    for (int i = 1; i < N && i < g0_cyc.size(); i++)
      chk("t1_gap", 32'(g0_cyc[i] - g0_cyc[i-1]), 1);
    chk("t1_ovf", 32'(ov0), 0);

    // 2: no request, 24 samples: two frames kept, third frame discarded
    do_reset();
    for (int i = 0; i < 3*N; i++) begin
      logic [W-1:0] r = W'($urandom);
      if (i == 2*N) chk("t2_ovf_before", 32'(ov0), 0);
      if (i < 2*N) put0(r);
      else begin v0 = 1'b1; s0 = r; @(posedge clk); #1; v0 = 1'b0; end
    end
    chk("t2_ovf_set", 32'(ov0), 1);
    chk("t2_no_out", 32'(g0_q.size()), 0);
    req0 = 1'b1;
    wait0("t2_cnt", 2*N, 100);
    cmp0("t2");
    chk("t2_ovf_sticky", 32'(ov0), 1);

    // 3: OUT_GAP=3, frame -1..-8
    do_reset();
    req1 = 1'b1;
    for (int i = 1; i <= N; i++) put1(W'(-i));
    k = 0;
    while (g1_q.size() < N && k < 120) begin @(posedge clk); k++; end
    #1 chk("t3_cnt", 32'(g1_q.size()), 32'(N));
    for (int i = 0; i < N && i < g1_q.size(); i++) chk("t3_data", g1_q[i], exp1[i]);
    for (int i = 1; i < N && i < g1_cyc.size(); i++)
      chk("t3_gap", 32'(g1_cyc[i] - g1_cyc[i-1]), 4);
    chk("t3_first", g1_q.size() > 0 ? g1_q[0] : 32'h0, 32'hFFFF_0000);

    // 4: ten frames of random data at a rate the reader sustains, request always high
    do_reset();
    req0 = 1'b1;
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < N; i++) put0(W'($urandom));
      repeat ($urandom_range(3, 6)) @(posedge clk);
      #1;
    end
    wait0("t4_cnt", 10*N, 300);
    cmp0("t4");
    chk("t4_ovf", 32'(ov0), 0);

    // 5: asynchronous reset while word 4 is on the output
    do_reset();
    req0 = 1'b1;
    for (int i = 0; i < N; i++) put0(W'($urandom));
    k = 0;
    while (g0_q.size() < 4 && k < 60) begin @(posedge clk); #3; k++; end
    chk("t5_mid", 32'(ce0), 1);
    rst = 1'b1;
    #1;
    chk("t5_ce0", 32'(ce0), 0);
    chk("t5_out0", so0, 0);
    chk("t5_fs0", 32'(fs0), 0);
    clear_caps();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("t5_no_done", 32'(d0_cyc.size()), 0);
    chk("t5_no_words", 32'(g0_q.size()), 0);
    for (int i = 0; i < N; i++) put0(W'($urandom));
    wait0("t5_cnt", N, 60);
    cmp0("t5");

    // 6: extreme values keep their sign in the real half
    do_reset();
    req0 = 1'b1;
    put0(16'h8000); put0(16'h7FFF); put0(16'h0001); put0(16'hFFFF);
    for (int i = 4; i < N; i++) put0(W'($urandom));
    wait0("t6_cnt", N, 60);
    cmp0("t6");
    chk("t6_min", g0_q.size() > 1 ? g0_q[0] : 32'h0, 32'h8000_0000);
    chk("t6_max", g0_q.size() > 1 ? g0_q[1] : 32'h0, 32'h7FFF_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always ends on its own
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
